// File: rtl/toll_pkg.sv
// Shared types and codes for the toll lane sequencer and its wait timer.
package toll_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_TAG = 3'd1,
    PAY      = 3'd2,
    OPEN     = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam logic [1:0] LAMP_OFF   = 2'b00;
  localparam logic [1:0] LAMP_GREEN = 2'b01;
  localparam logic [1:0] LAMP_RED   = 2'b10;

  localparam logic [1:0] WAIT_MODE_RUN = 2'b10;
  localparam logic [1:0] WAIT_MODE_CLR = 2'b00;

  // Lamp colour shown while the lane sits in a given state.
  function automatic logic [1:0] lamp_for(state_t s);
    case (s)
      PAY:        return LAMP_RED;
      OPEN, HOLD: return LAMP_GREEN;
      default:    return LAMP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/lane_timer.sv
// Up-counter with synchronous clear and enable; match flags count == term.
module lane_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         match
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

  assign match = (count == term);

endmodule

// File: rtl/toll_lane_ctrl.sv
// Per-lane toll gate sequencer: hipass wait window, manual pay fallback, exit hold.
// Optional TOLL_VIOLATION_EN adds viol/viol_cnt for car_exit seen while the gate is down.
module toll_lane_ctrl
  import toll_pkg::*;
#(
  parameter int WAIT_CYCLES = 7,
  parameter int HOLD_CYCLES = 16,
  parameter int TMR_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_det,
  input  logic       hipass_ok,
  input  logic       pay_done,
  input  logic       car_exit,
  output logic [1:0] wait_en,
  output logic       gate_open,
  output logic [1:0] lamp,
  output logic       fee_req,
  output logic [7:0] pass_cnt,
  output logic [2:0] state
`ifdef TOLL_VIOLATION_EN
  ,
  output logic       viol,
  output logic [7:0] viol_cnt
`endif
);

  localparam logic [TMR_W-1:0] WAIT_TERM = TMR_W'(WAIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_TERM = TMR_W'(HOLD_CYCLES - 1);

  state_t           cur, nxt;
  logic             tmr_clr, tmr_en, tmr_match, pass_inc;
  logic [TMR_W-1:0] tmr_term;

`ifdef TOLL_VIOLATION_EN
  logic stray_exit;
  assign stray_exit = car_exit && !gate_open;
`endif

  lane_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .match (tmr_match)
  );

  // Timer is held clear except while dwelling in WAIT_TAG or HOLD, so every entry starts at 0.
  always_comb begin
    nxt      = cur;
    tmr_clr  = 1'b1;
    tmr_en   = 1'b0;
    pass_inc = 1'b0;
    tmr_term = (cur == HOLD) ? HOLD_TERM : WAIT_TERM;
    case (cur)
      IDLE: if (car_det) nxt = WAIT_TAG;
      WAIT_TAG: begin
        if (hipass_ok)      nxt = OPEN;
        else if (!car_det)  nxt = IDLE;
        else if (tmr_match) nxt = PAY;
        else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      PAY: begin
        if (pay_done)        nxt = OPEN;
`ifdef TOLL_VIOLATION_EN
        else if (stray_exit) nxt = IDLE;
`endif
        else if (!car_det)   nxt = IDLE;
      end
      OPEN: if (car_exit) nxt = HOLD;
      HOLD: begin
        if (tmr_match) begin
          pass_inc = 1'b1;
          nxt      = car_det ? WAIT_TAG : IDLE;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= IDLE;
      pass_cnt  <= '0;
      wait_en   <= WAIT_MODE_CLR;
      gate_open <= 1'b0;
      lamp      <= LAMP_OFF;
      fee_req   <= 1'b0;
    end else begin
      cur       <= nxt;
      wait_en   <= (nxt == WAIT_TAG) ? WAIT_MODE_RUN : WAIT_MODE_CLR;
      gate_open <= (nxt == OPEN) || (nxt == HOLD);
      lamp      <= lamp_for(nxt);
      fee_req   <= (nxt == PAY);
      if (pass_inc) pass_cnt <= pass_cnt + 8'd1;
    end
  end

`ifdef TOLL_VIOLATION_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      viol     <= 1'b0;
      viol_cnt <= '0;
    end else begin
      viol <= stray_exit;
      if (stray_exit) viol_cnt <= viol_cnt + 8'd1;
    end
  end
`endif

  assign state = cur;

endmodule

// File: tb/tb_toll_lane_ctrl.sv
// Directed self-checking bench for toll_lane_ctrl (default parameters).
// Define TOLL_VIOLATION_EN to also exercise the violation outputs.
module tb_toll_lane_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       car_det = 1'b0, hipass_ok = 1'b0, pay_done = 1'b0, car_exit = 1'b0;
  logic [1:0] wait_en, lamp;
  logic       gate_open, fee_req;
  logic [7:0] pass_cnt;
  logic [2:0] state;
`ifdef TOLL_VIOLATION_EN
  logic       viol;
  logic [7:0] viol_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toll_lane_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .car_det   (car_det),
    .hipass_ok (hipass_ok),
    .pay_done  (pay_done),
    .car_exit  (car_exit),
    .wait_en   (wait_en),
    .gate_open (gate_open),
    .lamp      (lamp),
    .fee_req   (fee_req),
    .pass_cnt  (pass_cnt),
    .state     (state)
`ifdef TOLL_VIOLATION_EN
    ,
    .viol      (viol),
    .viol_cnt  (viol_cnt)
`endif
  );

  // Drive one cycle of inputs, let the edge sample them, then settle past the edge.
  task automatic applyStimulus(input logic cd, input logic ho, input logic pd,
                               input logic ce, input logic r);
    car_det   = cd;
    hipass_ok = ho;
    pay_done  = pd;
    car_exit  = ce;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One hipass passage ending back in IDLE: WAIT_TAG, OPEN, HOLD x16.
  task automatic quickPassage();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_state", 8'(state), 8'd0);
    checkOutput("rst_gate", 8'(gate_open), 8'd0);
    checkOutput("rst_lamp", 8'(lamp), 8'd0);
    checkOutput("rst_wait_en", 8'(wait_en), 8'd0);
    checkOutput("rst_fee", 8'(fee_req), 8'd0);
    checkOutput("rst_pass", pass_cnt, 8'd0);

    // Hipass tag on 3rd WAIT_TAG cycle, exit 5 cycles into OPEN
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t1_wait_state", 8'(state), 8'd1);
    checkOutput("t1_wait_en", 8'(wait_en), 8'h2);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("t1_open_state", 8'(state), 8'd3);
    checkOutput("t1_open_gate", 8'(gate_open), 8'd1);
    checkOutput("t1_open_lamp", 8'(lamp), 8'h1);
    checkOutput("t1_open_wait_en", 8'(wait_en), 8'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t1_open_ignores", 8'(state), 8'd3);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t1_hold_state", 8'(state), 8'd4);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_hold_last_gate", 8'(gate_open), 8'd1);
    checkOutput("t1_hold_last_pass", pass_cnt, 8'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_done_state", 8'(state), 8'd0);
    checkOutput("t1_done_gate", 8'(gate_open), 8'd0);
    checkOutput("t1_done_pass", pass_cnt, 8'd1);

    // No tag: PAY after 7 WAIT_TAG cycles, pay_done opens gate, car_det held at HOLD expiry
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t2_wait7_state", 8'(state), 8'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t2_pay_state", 8'(state), 8'd2);
    checkOutput("t2_pay_fee", 8'(fee_req), 8'd1);
    checkOutput("t2_pay_lamp", 8'(lamp), 8'h2);
    checkOutput("t2_pay_wait_en", 8'(wait_en), 8'h0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t2_pay_no_timeout", 8'(state), 8'd2);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("t2_open_state", 8'(state), 8'd3);
    checkOutput("t2_open_lamp", 8'(lamp), 8'h1);
    checkOutput("t2_open_fee", 8'(fee_req), 8'd0);
    applyStimulus(1, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t2_rewait_state", 8'(state), 8'd2 - 8'd1);
    checkOutput("t2_rewait_pass", pass_cnt, 8'd2);
    checkOutput("t2_rewait_gate", 8'(gate_open), 8'd0);

    // Already in WAIT_TAG cycle 1: tag arrives together with timeout on cycle 7
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t3_cycle7_state", 8'(state), 8'd1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("t3_tie_state", 8'(state), 8'd3);
    checkOutput("t3_tie_fee", 8'(fee_req), 8'd0);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_done_pass", pass_cnt, 8'd3);

    // Car backs out in WAIT_TAG cycle 2
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_backout_state", 8'(state), 8'd0);
    checkOutput("t4_backout_wait_en", 8'(wait_en), 8'h0);
    checkOutput("t4_backout_pass", pass_cnt, 8'd3);

`ifdef TOLL_VIOLATION_EN
    // Stray exit in IDLE flags a violation
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("v_idle_pulse", 8'(viol), 8'd1);
    checkOutput("v_idle_cnt", viol_cnt, 8'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("v_pulse_end", 8'(viol), 8'd0);
    // Stray exit in PAY returns to IDLE
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("v_pay_state", 8'(state), 8'd2);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("v_pay_idle", 8'(state), 8'd0);
    checkOutput("v_pay_cnt", viol_cnt, 8'd2);
    applyStimulus(0, 0, 0, 0, 0);
`else
    // Stray exit in IDLE is ignored
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("stray_exit_idle", 8'(state), 8'd0);
`endif

    // Wrap: 252 more passages reach 255, one more wraps to 0
    for (int p = 0; p < 252; p++) quickPassage();
    checkOutput("wrap_255", pass_cnt, 8'd255);
    quickPassage();
    checkOutput("wrap_0", pass_cnt, 8'd0);

    // Reset mid-HOLD drops the gate and clears the count
    quickPassage();
    checkOutput("pre_rst_pass", pass_cnt, 8'd1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_hold_state", 8'(state), 8'd4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_hold_gate", 8'(gate_open), 8'd0);
    checkOutput("rst_hold_pass", pass_cnt, 8'd0);
    checkOutput("rst_hold_state", 8'(state), 8'd0);
    checkOutput("rst_hold_lamp", 8'(lamp), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toll_lane_ctrl.md
# toll_lane_ctrl

Per-lane sequencer for the highway toll gate. It watches the entry loop, opens a bounded wait window for a hipass tag, and then either raises the gate or falls back to manual payment. After the car has left, it holds the gate open for a fixed time, closes it, and counts passages. It sits above the hipass wait-counter datapath, drives its 2-bit enable code, and consumes its tag result.

## Interface
Parameters:
- WAIT_CYCLES, 7: length of the hipass wait window in clk cycles (≥2).
- HOLD_CYCLES, 16: cycles the gate stays open after exit (≥1).
- TMR_W, 5: timer width; must hold max(WAIT_CYCLES, HOLD_CYCLES).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- car_det, in, 1: entry loop occupied (level).
- hipass_ok, in, 1: tag accepted from the wait counter (any nonzero hipass code, reduced upstream).
- pay_done, in, 1: manual payment confirmed (pulse).
- car_exit, in, 1: exit loop pulse.
- wait_en, out, 2: mode code to the hipass counter. 2'b10 = counting, 2'b00 = cleared.
- gate_open, out, 1: barrier up.
- lamp, out, 2: 00 off, 01 green, 10 red.
- fee_req, out, 1: manual payment requested.
- pass_cnt, out, 8: completed passages.
- state, out, 3: current FSM state (debug).

## Operation
- States: IDLE(0), WAIT_TAG(1), PAY(2), OPEN(3), HOLD(4). Encodings 5–7 are illegal and go to IDLE on the next edge.
- IDLE:
  - Outputs: wait_en=00, gate closed, lamp off.
  - car_det=1 → WAIT_TAG; timer loads 0.
- WAIT_TAG:
  - Outputs: wait_en=10, lamp off.
  - The timer increments each cycle.
  - Priority order: hipass_ok → OPEN; otherwise car_det=0 → IDLE (car backed out); otherwise timer==WAIT_CYCLES-1 → PAY.
  - hipass_ok wins over a timeout in the same cycle.
- PAY:
  - Outputs: fee_req=1, lamp red, wait_en=00.
  - pay_done → OPEN; otherwise car_det=0 → IDLE.
  - No timeout.
- OPEN:
  - Outputs: gate_open=1, lamp green.
  - car_exit → HOLD; timer loads 0.
  - car_det is ignored.
- HOLD:
  - Outputs: gate_open=1, lamp green.
  - The timer increments. At timer==HOLD_CYCLES-1, pass_cnt increments and the FSM leaves HOLD.
  - Next state is WAIT_TAG (timer reloads 0) if car_det=1 in that cycle, otherwise IDLE.
- pass_cnt wraps 255→0 and resets only on rst.
- hipass_ok, pay_done and car_exit arriving in states that do not consume them are ignored.

## Timing
- Moore machine. All outputs are registered or decoded from the state register, so they change one cycle after the qualifying input is sampled.
- WAIT_TAG lasts at most WAIT_CYCLES cycles before PAY.
- HOLD lasts exactly HOLD_CYCLES cycles.
- pass_cnt updates on the same edge that leaves HOLD.
- On reset, from any state, at the next clk edge:
  - state=IDLE, timer=0, pass_cnt=0, wait_en=00, gate_open=0, lamp=00, fee_req=0.
  - Reset mid-OPEN or mid-HOLD drops the gate immediately and does not count the passage.

## Configuration
- TOLL_VIOLATION_EN defined:
  - Adds outputs viol (1-bit pulse) and viol_cnt (8-bit, wrapping, reset 0).
  - car_exit while gate_open=0 pulses viol for one cycle and increments viol_cnt.
  - In PAY, such a car_exit also returns the FSM to IDLE.
- Undefined: those ports and logic are absent, and a stray car_exit is ignored.

## Structure
- Package toll_pkg holds:
  - the state enum;
  - lamp codes LAMP_OFF/GREEN/RED;
  - WAIT_MODE_RUN=2'b10 and WAIT_MODE_CLR=2'b00.
- Sub-module lane_timer: TMR_W-bit up-counter with synchronous clear, enable and a terminal-match output. One instance is shared between WAIT_TAG and HOLD.

## Test plan
- car_det=1, hipass_ok on the 3rd WAIT_TAG cycle, car_exit 5 cycles later → gate_open=1; after HOLD_CYCLES=16, gate_open=0 and pass_cnt=1.
- car_det=1, no tag → PAY after 7 cycles with fee_req=1 and lamp=10; pay_done → OPEN and lamp=01.
- hipass_ok and the timeout in the same cycle → OPEN, never PAY.
- car_det drops in WAIT_TAG cycle 2 → IDLE, wait_en=00, pass_cnt unchanged.
- car_det=1 at HOLD expiry → next state WAIT_TAG and pass_cnt increments; 256 passages → pass_cnt wraps to 0.
- rst asserted mid-HOLD → gate_open=0 and pass_cnt=0 next cycle. With TOLL_VIOLATION_EN, car_exit in IDLE → viol pulse and viol_cnt=1.
